controlador_busca_multicanal: RTL
=================================

Name: controlador_busca_multicanal

Overview:
- Parametrised successor of the top-level path-search controller FSM.
- Sequences initialise, active-node check, expand/update, path build and ready phases, as before.
- Adds:
  - N_EXP parallel expansion channels with a runtime channel mask.
  - An iteration limit and a per-state watchdog timeout.
  - An abort input, an error state with an error code, and an iteration counter.
- Sits at the top of the search datapath and drives the active-node evaluator, expansion units and path builder.

Parameters:
N_EXP, 4, number of expansion channels (1..16)
ITER_W, 16, width of iteration counter/limit
TMO_W, 12, width of watchdog counter/limit

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
iniciar_in  in  1  start/restart search
abortar_in  in  1  abort to idle, highest priority
cfg_canais_in  in  N_EXP  channel enable mask, sampled on start; all-zero means all channels
cfg_max_iter_in  in  ITER_W  iteration limit; 0 = unlimited
cfg_timeout_in  in  TMO_W  watchdog limit in cycles; 0 = disabled
tem_ativo_in  in  1  evaluator holds ≥1 active node
exp_ocupado_in  in  N_EXP  per-channel busy/approved flag
caminho_pronto_in  in  1  path builder done
lido_in  in  1  host has read result/error
aguardando_out  out  1  state IDLE
iniciar_out  out  1  state INICIALIZAR
tem_ativo_out  out  1  state TEM_ATIVO
expandir_out  out  N_EXP  latched mask while in EXPANDIR, else 0
construir_caminho_out  out  1  state CONSTRUIR
caminho_pronto_out  out  1  state PRONTO
erro_out  out  1  state ERRO
erro_codigo_out  out  2  00 none, 01 iteration limit, 10 timeout
iter_count_out  out  ITER_W  expansions completed in current/last search

Behaviour:
- Reset:
  - State is IDLE; mask, counters and erro_codigo_out are 0.
  - aguardando_out=1; all other outputs are 0.
- Output timing: all outputs decode registered state/registers only; there is no combinational input-to-output path.
- Priority per cycle: abortar_in > iniciar_in > state transitions.
  - abortar_in: next state IDLE from any state; erro_codigo_out and iter_count_out are held.
  - iniciar_in (no abort): next state INICIALIZAR from any state.
    - Latches cfg_canais_in; a zero mask is stored as all-ones.
    - Clears iter_count, watchdog and erro_codigo.
- INICIALIZAR: goes to TEM_ATIVO when tem_ativo_in=1.
- TEM_ATIVO:
  - If tem_ativo_in=0, go to CONSTRUIR.
  - Else, if cfg_max_iter_in≠0 and iter_count==cfg_max_iter_in, go to ERRO with code 01.
  - Else go to EXPANDIR.
- EXPANDIR:
  - iter_count increments on entry (saturates at all-ones).
  - Minimum dwell is 1 cycle: the exit condition is evaluated from the 2nd cycle in state.
  - Exit to TEM_ATIVO when (exp_ocupado_in & mask)==0; unmasked channels are ignored.
- CONSTRUIR: goes to PRONTO when caminho_pronto_in=1.
- PRONTO and ERRO: go to IDLE when lido_in=1.
- Watchdog:
  - Counter clears on every state change.
  - Counts cycles spent in INICIALIZAR, EXPANDIR or CONSTRUIR.
  - If cfg_timeout_in≠0 and the counter reaches cfg_timeout_in-1 with the state's exit condition still false, the next state is ERRO with code 10.
  - If the exit condition and the timeout occur in the same cycle, the normal exit wins.
- Config inputs other than cfg_canais_in are read live; changing them mid-search takes effect next cycle.
- Async reset mid-search returns to the reset state immediately.

Test Plan:
- Normal run, N_EXP=4, mask=0101, limits 0: start; tem_ativo=1 for 3 checks, each expansion with busy bits 0101 dropping after 2 cycles → expandir_out=0101 three times, PRONTO after caminho_pronto, iter_count_out=3, IDLE after lido.
- Unmasked busy: mask=0001 with exp_ocupado_in=1110 held → EXPANDIR exits on the 2nd cycle in state.
- Iteration limit: cfg_max_iter=2, tem_ativo held 1 → two expansions, then ERRO, erro_codigo_out=01, iter_count_out=2; lido → IDLE.
- Timeout: cfg_timeout=5, CONSTRUIR entered with caminho_pronto never set → ERRO with code 10 after exactly 5 cycles in CONSTRUIR; caminho_pronto on the 5th cycle → PRONTO instead.
- Priority: abortar_in and iniciar_in asserted together during EXPANDIR → IDLE. Iniciar alone from ERRO → INICIALIZAR with code cleared to 00.
- Zero mask: cfg_canais_in=0 at start → expandir_out=1111. Async reset asserted during EXPANDIR → aguardando_out=1 immediately and all counters 0.

Source files
------------

// File: rtl/controlador_busca_multicanal.sv
// controlador_busca_multicanal: path-search controller FSM with masked parallel
// expansion channels, iteration limit, per-state watchdog, abort and error reporting.
module controlador_busca_multicanal #(
    parameter int N_EXP  = 4,
    parameter int ITER_W = 16,
    parameter int TMO_W  = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              iniciar_in,
    input  logic              abortar_in,
    input  logic [N_EXP-1:0]  cfg_canais_in,
    input  logic [ITER_W-1:0] cfg_max_iter_in,
    input  logic [TMO_W-1:0]  cfg_timeout_in,
    input  logic              tem_ativo_in,
    input  logic [N_EXP-1:0]  exp_ocupado_in,
    input  logic              caminho_pronto_in,
    input  logic              lido_in,
    output logic              aguardando_out,
    output logic              iniciar_out,
    output logic              tem_ativo_out,
    output logic [N_EXP-1:0]  expandir_out,
    output logic              construir_caminho_out,
    output logic              caminho_pronto_out,
    output logic              erro_out,
    output logic [1:0]        erro_codigo_out,
    output logic [ITER_W-1:0] iter_count_out
);
    typedef enum logic [2:0] {IDLE, INICIALIZAR, TEM_ATIVO, EXPANDIR, CONSTRUIR, PRONTO, ERRO} estado_t;

    estado_t           r_estado, w_prox;
    logic [N_EXP-1:0]  r_mask;
    logic [ITER_W-1:0] r_iter;
    logic [TMO_W-1:0]  r_wdog;
    logic [1:0]        r_erro, w_erro;
    logic              w_inicio, w_tmo, w_conta;

    assign w_inicio = iniciar_in && !abortar_in;
    assign w_tmo    = (cfg_timeout_in != '0) && (r_wdog == cfg_timeout_in - TMO_W'(1));
    assign w_conta  = (r_estado == INICIALIZAR) || (r_estado == EXPANDIR) || (r_estado == CONSTRUIR);

    always_comb begin
        w_prox = r_estado;
        w_erro = r_erro;
        case (r_estado)
            INICIALIZAR:
                if (tem_ativo_in) w_prox = TEM_ATIVO;
                else if (w_tmo) begin w_prox = ERRO; w_erro = 2'b10; end
            TEM_ATIVO:
                if (!tem_ativo_in) w_prox = CONSTRUIR;
                else if (cfg_max_iter_in != '0 && r_iter == cfg_max_iter_in) begin w_prox = ERRO; w_erro = 2'b01; end
                else w_prox = EXPANDIR;
            // a zero watchdog count marks the first cycle in EXPANDIR, where the exit is not yet allowed
            EXPANDIR:
                if (r_wdog != '0 && (exp_ocupado_in & r_mask) == '0) w_prox = TEM_ATIVO;
                else if (w_tmo) begin w_prox = ERRO; w_erro = 2'b10; end
            CONSTRUIR:
                if (caminho_pronto_in) w_prox = PRONTO;
                else if (w_tmo) begin w_prox = ERRO; w_erro = 2'b10; end
            PRONTO, ERRO:
                if (lido_in) w_prox = IDLE;
            default: w_prox = r_estado;
        endcase
        if (abortar_in) begin
            w_prox = IDLE;
            w_erro = r_erro;
        end else if (iniciar_in) begin
            w_prox = INICIALIZAR;
            w_erro = 2'b00;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_estado <= IDLE;
            r_mask   <= '0;
            r_iter   <= '0;
            r_wdog   <= '0;
            r_erro   <= 2'b00;
        end else begin
            r_estado <= w_prox;
            r_erro   <= w_erro;
            if (w_inicio) r_mask <= (cfg_canais_in == '0) ? '1 : cfg_canais_in;
            r_iter <= w_inicio ? '0 :
                      (r_estado == TEM_ATIVO && w_prox == EXPANDIR && !(&r_iter)) ? r_iter + ITER_W'(1) : r_iter;
            r_wdog <= (w_inicio || w_prox != r_estado || !w_conta) ? '0 :
                      (&r_wdog) ? r_wdog : r_wdog + TMO_W'(1);
        end
    end

    assign aguardando_out        = (r_estado == IDLE);
    assign iniciar_out           = (r_estado == INICIALIZAR);
    assign tem_ativo_out         = (r_estado == TEM_ATIVO);
    assign expandir_out          = (r_estado == EXPANDIR) ? r_mask : '0;
    assign construir_caminho_out = (r_estado == CONSTRUIR);
    assign caminho_pronto_out    = (r_estado == PRONTO);
    assign erro_out              = (r_estado == ERRO);
    assign erro_codigo_out       = r_erro;
    assign iter_count_out        = r_iter;
endmodule
